// File: rtl/ctrl_pkg.sv
// Shared definitions for the HPS command controller: FSM states, opcode width and encodings.
// Kept in step with the ImageProcessor opcode decoder.
package ctrl_pkg;

  localparam int unsigned CTRL_OPCODE_W = 3;
  localparam int unsigned CTRL_NUM_OPS  = 5;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StProcess  = 2'd1,
    StDoneWait = 2'd2
  } ctrl_state_e;

  typedef enum logic [CTRL_OPCODE_W-1:0] {
    Op0 = 3'd0,
    Op1 = 3'd1,
    Op2 = 3'd2,
    Op3 = 3'd3,
    Op4 = 3'd4
  } ctrl_op_e;

  function automatic logic op_valid(input int unsigned op, input int unsigned num_ops);
    return op < num_ops;
  endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// PROCESS-phase watchdog; only built and instantiated when CTRL_TIMEOUT_EN is defined.
// expired rises once TIMEOUT-1 counted cycles have elapsed since the last clear.
`ifdef CTRL_TIMEOUT_EN
module ctrl_watchdog #(
  parameter int unsigned TIMEOUT = 2**20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif

// File: rtl/hps_op_controller.sv
// HPS<->FPGA command controller: validates the opcode, drives the ImageProcessor and answers
// the HPS over a 4-phase enable/done handshake. Optional watchdog under CTRL_TIMEOUT_EN.
module hps_op_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned          OPCODE_W   = CTRL_OPCODE_W,
  parameter int unsigned          NUM_OPS    = CTRL_NUM_OPS,
  parameter logic [NUM_OPS-1:0]   WRITE_MASK = '1,
  parameter int unsigned          CNT_W      = 16
`ifdef CTRL_TIMEOUT_EN
  ,
  parameter int unsigned          TIMEOUT    = 2**20
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_from_hps,
  input  logic [OPCODE_W-1:0] opcode_from_hps,
  input  logic                done_from_processor,
  output logic                enable,
  output logic                wren,
  output logic [OPCODE_W-1:0] opcode,
  output logic                done_to_hps,
  output logic                error_to_hps,
  output logic                busy_to_hps,
  output logic [CNT_W-1:0]    run_count,
  output logic                processing_has_run_once
);

  ctrl_state_e state;
  logic        op_ok;
  logic        wr_sel;
  logic        wd_expired;

  assign op_ok = op_valid(32'(opcode_from_hps), NUM_OPS);

  always_comb begin
    wr_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (opcode_from_hps == OPCODE_W'(i)) wr_sel = WRITE_MASK[i];
    end
  end

`ifdef CTRL_TIMEOUT_EN
  ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (state != StProcess),
    .count_en (state == StProcess),
    .expired  (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= StIdle;
      enable                  <= 1'b0;
      wren                    <= 1'b0;
      opcode                  <= '0;
      done_to_hps             <= 1'b0;
      error_to_hps            <= 1'b0;
      busy_to_hps             <= 1'b0;
      run_count               <= '0;
      processing_has_run_once <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (enable_from_hps) begin
            opcode      <= opcode_from_hps;
            busy_to_hps <= 1'b1;
            if (op_ok) begin
              state  <= StProcess;
              enable <= 1'b1;
              wren   <= wr_sel;
            end else begin
              state        <= StDoneWait;
              done_to_hps  <= 1'b1;
              error_to_hps <= 1'b1;
            end
          end
        end
        StProcess: begin
          // A processor done on the same edge as the watchdog expiry counts as success.
          if (done_from_processor) begin
            state                   <= StDoneWait;
            enable                  <= 1'b0;
            wren                    <= 1'b0;
            done_to_hps             <= 1'b1;
            error_to_hps            <= 1'b0;
            processing_has_run_once <= 1'b1;
            if (run_count != '1) run_count <= run_count + CNT_W'(1);
          end else if (wd_expired) begin
            state        <= StDoneWait;
            enable       <= 1'b0;
            wren         <= 1'b0;
            done_to_hps  <= 1'b1;
            error_to_hps <= 1'b1;
          end
        end
        StDoneWait: begin
          if (!enable_from_hps) begin
            state        <= StIdle;
            done_to_hps  <= 1'b0;
            error_to_hps <= 1'b0;
            busy_to_hps  <= 1'b0;
          end
        end
        default: begin
          state        <= StIdle;
          enable       <= 1'b0;
          wren         <= 1'b0;
          done_to_hps  <= 1'b0;
          error_to_hps <= 1'b0;
          busy_to_hps  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hps_op_controller.sv
// Self-checking bench for hps_op_controller: transaction-level timeline model with randomized
// opcodes, processor latencies and HPS hold times. Watchdog cases apply with CTRL_TIMEOUT_EN.
module tb_hps_op_controller;

  localparam int unsigned OPCODE_W   = 3;
  localparam int unsigned NUM_OPS    = 5;
  localparam int unsigned CNT_W      = 3;
  localparam logic [4:0]  WRITE_MASK = 5'b00001;
`ifdef CTRL_TIMEOUT_EN
  localparam int unsigned TIMEOUT    = 16;
`endif
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                en_hps;
  logic [OPCODE_W-1:0] op_hps;
  logic                done_proc;
  logic                enable;
  logic                wren;
  logic [OPCODE_W-1:0] opcode;
  logic                done_to_hps;
  logic                error_to_hps;
  logic                busy_to_hps;
  logic [CNT_W-1:0]    run_count;
  logic                has_run;

  int tests = 0;
  int fails = 0;
  int exp_runs = 0;
  bit exp_ran = 1'b0;

  hps_op_controller #(
    .OPCODE_W   (OPCODE_W),
    .NUM_OPS    (NUM_OPS),
    .WRITE_MASK (WRITE_MASK),
    .CNT_W      (CNT_W)
`ifdef CTRL_TIMEOUT_EN
    ,
    .TIMEOUT    (TIMEOUT)
`endif
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable_from_hps         (en_hps),
    .opcode_from_hps         (op_hps),
    .done_from_processor     (done_proc),
    .enable                  (enable),
    .wren                    (wren),
    .opcode                  (opcode),
    .done_to_hps             (done_to_hps),
    .error_to_hps            (error_to_hps),
    .busy_to_hps             (busy_to_hps),
    .run_count               (run_count),
    .processing_has_run_once (has_run)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_count();
    return (exp_runs > CNT_MAX) ? CNT_MAX : exp_runs;
  endfunction

  // One full HPS command: request, processing for d idle cycles, h extra hold cycles, release.
  task automatic run_txn(input int op, input int d, input int h, input bit drop);
    logic [4:0] mask = WRITE_MASK;
    bit valid = (op < NUM_OPS);
    bit exp_err = !valid;
    bit tmo = 1'b0;
    int last = d + 1;
    en_hps    = 1'b1;
    op_hps    = OPCODE_W'(op);
    done_proc = 1'($urandom_range(0, 1));
    step();
    chk("req_busy", 32'(busy_to_hps), 32'd1);
    chk("req_opcode", 32'(opcode), 32'(op));
    chk("req_done", 32'(done_to_hps), 32'(!valid));
    chk("req_error", 32'(error_to_hps), 32'(!valid));
    chk("req_enable", 32'(enable), 32'(valid));
    chk("req_wren", 32'(wren), 32'(valid && mask[op % 5]));
    if (valid) begin
      op_hps = OPCODE_W'($urandom);
`ifdef CTRL_TIMEOUT_EN
      if (last > int'(TIMEOUT)) begin
        last = TIMEOUT;
        tmo  = 1'b1;
      end
`endif
      for (int k = 1; k <= last; k++) begin
        done_proc = (k == d + 1);
        if (drop) en_hps = 1'b0;
        step();
        if (k < last) begin
          chk("proc_enable", 32'(enable), 32'd1);
          chk("proc_wren", 32'(wren), 32'(mask[op]));
          chk("proc_done", 32'(done_to_hps), 32'd0);
        end
      end
      done_proc = 1'b0;
      if (!tmo) begin
        exp_runs++;
        exp_ran = 1'b1;
      end
      exp_err = tmo;
      chk("fin_done", 32'(done_to_hps), 32'd1);
      chk("fin_error", 32'(error_to_hps), 32'(tmo));
      chk("fin_enable", 32'(enable), 32'd0);
      chk("fin_wren", 32'(wren), 32'd0);
      chk("fin_run_count", 32'(run_count), 32'(exp_count()));
      chk("fin_has_run", 32'(has_run), 32'(exp_ran));
    end
    if (!drop) begin
      for (int i = 0; i < h; i++) begin
        done_proc = 1'($urandom_range(0, 1));
        step();
        chk("hold_done", 32'(done_to_hps), 32'd1);
        chk("hold_error", 32'(error_to_hps), 32'(exp_err));
        chk("hold_busy", 32'(busy_to_hps), 32'd1);
        chk("hold_enable", 32'(enable), 32'd0);
      end
    end
    en_hps    = 1'b0;
    done_proc = 1'($urandom_range(0, 1));
    step();
    chk("rel_done", 32'(done_to_hps), 32'd0);
    chk("rel_error", 32'(error_to_hps), 32'd0);
    chk("rel_busy", 32'(busy_to_hps), 32'd0);
    chk("rel_enable", 32'(enable), 32'd0);
    chk("rel_run_count", 32'(run_count), 32'(exp_count()));
    chk("rel_has_run", 32'(has_run), 32'(exp_ran));
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      done_proc = 1'($urandom_range(0, 1));
      step();
      chk("idle_busy", 32'(busy_to_hps), 32'd0);
      chk("idle_enable", 32'(enable), 32'd0);
      chk("idle_done", 32'(done_to_hps), 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    en_hps    = 1'b0;
    op_hps    = '0;
    done_proc = 1'b0;
    step();
    step();
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_done", 32'(done_to_hps), 32'd0);
    chk("rst_error", 32'(error_to_hps), 32'd0);
    chk("rst_busy", 32'(busy_to_hps), 32'd0);
    chk("rst_run_count", 32'(run_count), 32'd0);
    chk("rst_has_run", 32'(has_run), 32'd0);
    reset = 1'b0;
    idle_gap(2);

    // Directed: normal op, invalid op, write-mask cases, long hold, immediate re-request.
    run_txn(2, 9, 0, 1'b0);
    run_txn(6, 0, 2, 1'b0);
    run_txn(3, 4, 1, 1'b0);
    run_txn(0, 2, 0, 1'b0);
    run_txn(1, 3, 5, 1'b0);
    run_txn(4, 1, 0, 1'b0);
    run_txn(2, 5, 0, 1'b1);
    run_txn(7, 0, 0, 1'b1);
    run_txn(1, 15, 1, 1'b0);
    run_txn(3, 20, 1, 1'b0);
    run_txn(0, 0, 0, 1'b0);
    run_txn(4, 2, 0, 1'b0);

    // Randomized commands.
    for (int t = 0; t < 24; t++) begin
      run_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 3) == 0));
      idle_gap(int'($urandom_range(0, 2)));
    end

    // Reset in the middle of PROCESS with the HPS request still held high.
    en_hps    = 1'b1;
    op_hps    = 3'd1;
    done_proc = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    exp_runs = 0;
    exp_ran  = 1'b0;
    chk("midrst_enable", 32'(enable), 32'd0);
    chk("midrst_done", 32'(done_to_hps), 32'd0);
    chk("midrst_busy", 32'(busy_to_hps), 32'd0);
    chk("midrst_run_count", 32'(run_count), 32'd0);
    chk("midrst_has_run", 32'(has_run), 32'd0);
    reset = 1'b0;
    run_txn(1, 3, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
